// File: rtl/gray_digit_entry_if.sv
// gray_digit_entry_if
//   Bundles the switch/button inputs and the digit/number outputs of the
//   Gray-code digit entry stage.
//   master : drives ag..dg, btn_load and btn_clear, and observes the results.
//   slave  : the entry stage itself, which reads the inputs and drives
//            bcd_unidades/decenas/centenas, value_bin, digit_count,
//            number_valid, digit_stb and err_stb.
interface gray_digit_entry_if;
   logic       ag;
   logic       bg;
   logic       cg;
   logic       dg;
   logic       btn_load;
   logic       btn_clear;
   logic [3:0] bcd_unidades;
   logic [3:0] bcd_decenas;
   logic [3:0] bcd_centenas;
   logic [9:0] value_bin;
   logic [1:0] digit_count;
   logic       number_valid;
   logic       digit_stb;
   logic       err_stb;

   modport master (
      output ag, bg, cg, dg, btn_load, btn_clear,
      input  bcd_unidades, bcd_decenas, bcd_centenas, value_bin,
             digit_count, number_valid, digit_stb, err_stb
   );

   modport slave (
      input  ag, bg, cg, dg, btn_load, btn_clear,
      output bcd_unidades, bcd_decenas, bcd_centenas, value_bin,
             digit_count, number_valid, digit_stb, err_stb
   );
endinterface

// File: rtl/gray_digit_entry.sv
// gray_digit_entry
//   Input stage of the Gray-code decimal display path. The asynchronous
//   switches (ag = MSB .. dg = LSB) and the two raw buttons are synchronised,
//   the buttons are debounced, and each load event converts the Gray value
//   to binary and shifts it in as a decimal digit. Up to three digits are
//   held as BCD plus their binary value.
//
//   Ports:
//     clk  - system clock (27 MHz)
//     rst  - asynchronous, active-high reset
//     bus  - gray_digit_entry_if.slave: switch/button inputs, BCD digits,
//            value_bin (0..999), digit_count, number_valid, and the
//            one-cycle digit_stb / err_stb pulses
//
//   Parameters:
//     SYNC_STAGES - synchroniser depth (>= 2)
//     DEB_CYCLES  - stable cycles needed before a debounced level changes
//
//   Optional build macro GRAY_STABLE_EN: when defined, a load is accepted
//   only if the synchronised Gray bits have been unchanged for at least
//   DEB_CYCLES cycles; otherwise it is rejected with err_stb.
module gray_digit_entry #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 270000
) (
   input  logic              clk,
   input  logic              rst,
   gray_digit_entry_if.slave bus
);

   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ENTRY = 2'd1,
      FULL  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchronisers: {ag, bg, cg, dg, btn_load, btn_clear}
   // ------------------------------------------------------------------
   logic [5:0] sync_pipe [SYNC_STAGES];
   logic [5:0] sync_out;

   // NOTE: the synchroniser array is small and must not show stale switch
   // values after reset, so every stage is cleared, unlike a data RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the old
         // value of its predecessor, forming a true shift chain.
         sync_pipe[0] <= {bus.ag, bus.bg, bus.cg, bus.dg, bus.btn_load, bus.btn_clear};
         for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      end
   end

   assign sync_out = sync_pipe[SYNC_STAGES-1];

   logic [3:0] gray_s;
   logic [1:0] btn_s;   // [1] = load, [0] = clear
   assign gray_s = sync_out[5:2];
   assign btn_s  = sync_out[1:0];

   // ------------------------------------------------------------------
   // Debounce and rising-edge event detection, one lane per button
   // ------------------------------------------------------------------
   logic [CW-1:0] deb_cnt [2];
   logic [1:0]    deb_lvl;
   logic [1:0]    deb_q;
   logic [1:0]    btn_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
         deb_lvl <= '0;
         deb_q   <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (btn_s[b] == deb_lvl[b]) begin
               deb_cnt[b] <= '0;
            end else if (deb_cnt[b] == DEB_MAX) begin
               deb_lvl[b] <= btn_s[b];
               deb_cnt[b] <= '0;
            end else begin
               deb_cnt[b] <= deb_cnt[b] + CW'(1);
            end
         end
         deb_q <= deb_lvl;
      end
   end

   assign btn_evt = deb_lvl & ~deb_q;

   logic load_evt;
   logic clr_evt;
   assign load_evt = btn_evt[1];
   assign clr_evt  = btn_evt[0];

   // ------------------------------------------------------------------
   // Optional Gray stability qualifier
   // ------------------------------------------------------------------
   logic gray_stable;

`ifdef GRAY_STABLE_EN
   localparam logic [CW-1:0] STAB_MAX = CW'(DEB_CYCLES);

   logic [3:0]    gray_prev;
   logic [CW-1:0] stab_cnt;

   // Counts cycles the synchronised Gray value has held, saturating once
   // it has been stable long enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gray_prev <= '0;
         stab_cnt  <= '0;
      end else begin
         gray_prev <= gray_s;
         if (gray_s != gray_prev)    stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + CW'(1);
      end
   end

   assign gray_stable = (stab_cnt == STAB_MAX);
`else
   assign gray_stable = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Gray to binary
   // ------------------------------------------------------------------
   logic [3:0] bin;
   assign bin[3] = gray_s[3];
   assign bin[2] = bin[3] ^ gray_s[2];
   assign bin[1] = bin[2] ^ gray_s[1];
   assign bin[0] = bin[1] ^ gray_s[0];

   // ------------------------------------------------------------------
   // Entry FSM and digit registers
   // ------------------------------------------------------------------
   state_t     state,     state_n;
   logic [3:0] dig_u,     dig_u_n;
   logic [3:0] dig_d,     dig_d_n;
   logic [3:0] dig_c,     dig_c_n;
   logic [9:0] value,     value_n;
   logic [1:0] count,     count_n;
   logic       stb_digit, stb_digit_n;
   logic       stb_err,   stb_err_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         dig_u     <= '0;
         dig_d     <= '0;
         dig_c     <= '0;
         value     <= '0;
         count     <= '0;
         stb_digit <= 1'b0;
         stb_err   <= 1'b0;
      end else begin
         state     <= state_n;
         dig_u     <= dig_u_n;
         dig_d     <= dig_d_n;
         dig_c     <= dig_c_n;
         value     <= value_n;
         count     <= count_n;
         stb_digit <= stb_digit_n;
         stb_err   <= stb_err_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block is given a hold/idle value first,
      // so no path can leave one unassigned and infer a latch.
      state_n     = state;
      dig_u_n     = dig_u;
      dig_d_n     = dig_d;
      dig_c_n     = dig_c;
      value_n     = value;
      count_n     = count;
      stb_digit_n = 1'b0;
      stb_err_n   = 1'b0;

      // Clear has priority over a coincident load and issues no strobe.
      if (clr_evt) begin
         state_n = EMPTY;
         dig_u_n = '0;
         dig_d_n = '0;
         dig_c_n = '0;
         value_n = '0;
         count_n = '0;
      end else if (load_evt) begin
         if (state == FULL || bin > 4'd9 || !gray_stable) begin
            stb_err_n = 1'b1;
         end else begin
            dig_c_n     = dig_d;
            dig_d_n     = dig_u;
            dig_u_n     = bin;
            // value*10 + digit; at most 99*10+9, so 10 bits never overflow.
            value_n     = (value << 3) + (value << 1) + {6'd0, bin};
            count_n     = count + 2'd1;
            stb_digit_n = 1'b1;
            state_n     = (count == 2'd2) ? FULL : ENTRY;
         end
      end
   end

   assign bus.bcd_unidades = dig_u;
   assign bus.bcd_decenas  = dig_d;
   assign bus.bcd_centenas = dig_c;
   assign bus.value_bin    = value;
   assign bus.digit_count  = count;
   assign bus.number_valid = (state == FULL);
   assign bus.digit_stb    = stb_digit;
   assign bus.err_stb      = stb_err;

endmodule
